uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, receive FIFO depth in bytes (power of 2, 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_flag  input  1  byte-ready flag from UART receiver.
REQ-005 SHALL have port Rx_Data  input  8  received byte from UART receiver, valid while rx_flag=1.
REQ-006 SHALL have port parity_error  input  1  parity status of Rx_Data, valid while rx_flag=1.
REQ-007 SHALL have port rx_flag_clr  output  1  registered one-cycle clear request to UART receiver.
REQ-008 SHALL have port rd_en  input  1  CPU pop request.
REQ-009 SHALL have port rd_data  output  8  head byte, first-word fall-through.
REQ-010 SHALL have port flush  input  1  synchronous FIFO empty command.
REQ-011 SHALL have port ovr_clr  input  1  clears sticky overrun.
REQ-012 SHALL have ports empty, full  output  1 each  FIFO status, combinational from count.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  stored byte count.
REQ-014 SHALL have port overrun  output  1  sticky: byte lost because FIFO full.

Function
REQ-015 SHALL implement FSM RXF_IDLE, RXF_CAPTURE, RXF_CLEAR, RXF_WAIT_LOW.
REQ-016 RXF_IDLE: rx_flag=1 -> RXF_CAPTURE; else stay.
REQ-017 RXF_CAPTURE: one cycle; pushes Rx_Data on exiting edge; -> RXF_CLEAR.
REQ-018 RXF_CLEAR: rx_flag_clr=1 for exactly this one cycle; -> RXF_WAIT_LOW.
REQ-019 RXF_WAIT_LOW: stay while rx_flag=1; rx_flag=0 -> RXF_IDLE; one push per rx_flag assertion.
REQ-020 Latency: rx_flag rising seen at edge N -> byte in FIFO, count incremented, after edge N+1; rx_flag_clr high in cycle after edge N+1.
REQ-021 rd_data SHALL equal mem[rd_ptr] combinationally; undefined-but-stable (last head) when empty.
REQ-022 rd_en with empty=0 SHALL advance rd_ptr and decrement count; rd_en with empty=1 ignored, no state change.
REQ-023 Push and pop same edge: both performed, count unchanged; push with full=1 and pop same edge: push accepted, count stays DEPTH.
REQ-024 Push with full=1 and no pop: byte dropped, overrun set to 1; handshake still completes.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-026 flush SHALL zero pointers and count on next edge; flush overrides push and pop same cycle; FSM unaffected.
REQ-027 ovr_clr clears overrun; overrun set in same cycle as ovr_clr wins (remains 1).

Reset
REQ-028 n_rst=0 SHALL asynchronously force state RXF_IDLE, pointers 0, count 0, empty=1, full=0, overrun=0, rx_flag_clr=0; storage array not reset.
REQ-029 Reset mid-handshake SHALL abandon it; after release, a still-high rx_flag SHALL be captured as new byte.

Configuration
REQ-030 With UART_RX_PARITY_DISCARD_EN defined: byte with parity_error=1 SHALL NOT be pushed, handshake still completes, and an 8-bit saturating output parity_drop_cnt SHALL increment (reset 0, cleared by flush).
REQ-031 Without UART_RX_PARITY_DISCARD_EN: parity_error ignored, every byte pushed, parity_drop_cnt port absent.

Structure
REQ-032 uart_pkg SHALL hold typedef enum rx_fifo_state_t and constant UART_RX_FIFO_DEPTH=8.
REQ-033 Storage SHALL be sub-module uart_fifo_mem (DEPTH x 8, one write port, async read); FSM, pointers and flags in uart_rx_fifo.

Verification
REQ-034 Single byte: rx_flag=1 with Rx_Data=0xA5 held until rx_flag_clr -> count=1, rd_data=0xA5, one rx_flag_clr pulse, then rd_en -> empty=1.
REQ-035 Fill: DEPTH+1 bytes 0x00..0x08 without pops -> full=1 after 8, overrun=1, readout 0x00..0x07 in order, 0x08 lost.
REQ-036 Simultaneous: FIFO holds 3, push 0x5A with rd_en same cycle -> count stays 3, pointer wrap verified over 20 bytes.
REQ-037 Flush/ovr_clr: flush while push in RXF_CAPTURE -> count=0, empty=1; ovr_clr -> overrun=0.
REQ-038 Reset: n_rst low in RXF_CLEAR -> outputs at reset values immediately; rx_flag still high after release -> byte re-captured.
REQ-039 With UART_RX_PARITY_DISCARD_EN: bytes 0x11 (parity_error=1), 0x22 (0) -> count=1, rd_data=0x22, parity_drop_cnt=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive FIFO.
package uart_pkg;

  localparam int unsigned UART_RX_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    RXF_IDLE,
    RXF_CAPTURE,
    RXF_CLEAR,
    RXF_WAIT_LOW
  } rx_fifo_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-handshake and CPU-side bus of the UART receive FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH = uart_pkg::UART_RX_FIFO_DEPTH
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          rx_flag;
  logic [7:0]    Rx_Data;
  logic          parity_error;
  logic          rx_flag_clr;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          flush;
  logic          ovr_clr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;

  modport master (
    output rx_flag, Rx_Data, parity_error, rd_en, flush, ovr_clr,
    input  rx_flag_clr, rd_data, empty, full, count, overrun
  );

  modport slave (
    input  rx_flag, Rx_Data, parity_error, rd_en, flush, ovr_clr,
    output rx_flag_clr, rd_data, empty, full, count, overrun
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one write port, asynchronous read, no reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: handshakes bytes off a UART receiver into a first-word fall-through queue.
// Define UART_RX_PARITY_DISCARD_EN to drop bytes flagged with a parity error and count them.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          n_rst,
  uart_rx_fifo_if.slave bus
`ifdef UART_RX_PARITY_DISCARD_EN
  ,
  output logic [7:0]    parity_drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rx_fifo_state_t state, state_next;
  logic           rx_flag_clr_q, rx_flag_clr_next;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_q;
  logic           overrun_q;
  logic [7:0]     head;

  logic empty_c, full_c, push_c, keep_c, pop_c, accept_c, drop_c;

  // Receiver handshake: next state and the clear pulse that accompanies RXF_CLEAR
  always_comb begin
    state_next       = state;
    rx_flag_clr_next = 1'b0;
    case (state)
      RXF_IDLE:     if (bus.rx_flag) state_next = RXF_CAPTURE;
      RXF_CAPTURE:  state_next = RXF_CLEAR;
      RXF_CLEAR:    state_next = RXF_WAIT_LOW;
      RXF_WAIT_LOW: if (!bus.rx_flag) state_next = RXF_IDLE;
      default:      state_next = RXF_IDLE;
    endcase
    rx_flag_clr_next = (state_next == RXF_CLEAR);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= RXF_IDLE;
      rx_flag_clr_q <= 1'b0;
    end else begin
      state         <= state_next;
      rx_flag_clr_q <= rx_flag_clr_next;
    end
  end

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign push_c  = (state == RXF_CAPTURE);
  assign pop_c   = bus.rd_en & ~empty_c;

`ifdef UART_RX_PARITY_DISCARD_EN
  assign keep_c = push_c & ~bus.parity_error;
`else
  logic unused_parity;
  assign unused_parity = bus.parity_error;
  assign keep_c        = push_c;
`endif

  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign accept_c = keep_c & (~full_c | pop_c);
  assign drop_c   = keep_c & full_c & ~pop_c;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (accept_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overrun; a new loss beats a simultaneous clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) overrun_q <= 1'b0;
    else        overrun_q <= (drop_c & ~bus.flush) | (overrun_q & ~bus.ovr_clr);
  end

`ifdef UART_RX_PARITY_DISCARD_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                              parity_drop_cnt <= '0;
    else if (bus.flush)                                      parity_drop_cnt <= '0;
    else if (push_c && bus.parity_error && parity_drop_cnt != 8'hFF)
                                                             parity_drop_cnt <= parity_drop_cnt + 8'd1;
  end
`endif

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept_c & ~bus.flush),
    .waddr (wr_ptr),
    .wdata (bus.Rx_Data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.rd_data     = head;
  assign bus.count       = count_q;
  assign bus.empty       = empty_c;
  assign bus.full        = full_c;
  assign bus.overrun     = overrun_q;
  assign bus.rx_flag_clr = rx_flag_clr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = UART_RX_FIFO_DEPTH;
`ifdef UART_RX_PARITY_DISCARD_EN
  localparam bit DISCARD = 1'b1;
  logic [7:0] parity_drop_cnt;
`else
  localparam bit DISCARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
`ifdef UART_RX_PARITY_DISCARD_EN
    ,
    .parity_drop_cnt (parity_drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents in arrival order, sticky overrun, parity drops
  logic [7:0] q[$];
  bit         m_ovr  = 1'b0;
  int         m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},   32'(bus.count),   32'(q.size()));
    chk({tag, ".empty"},   32'(bus.empty),   32'(q.size() == 0));
    chk({tag, ".full"},    32'(bus.full),    32'(q.size() == DEPTH));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
    if (q.size() > 0) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(q[0]));
`ifdef UART_RX_PARITY_DISCARD_EN
    chk({tag, ".drop_cnt"}, 32'(parity_drop_cnt), 32'(m_drop));
`endif
  endtask

  // mode: 0 plain, 1 rd_en on the push edge, 2 flush on the push edge, 3 ovr_clr on the push edge
  task automatic send_byte(input logic [7:0] d, input logic perr, input int mode, input int hold);
    int n0;
    @(negedge clk);
    bus.rx_flag = 1'b1; bus.Rx_Data = d; bus.parity_error = perr;
    n0 = q.size();
    @(posedge clk);
    @(negedge clk);
    chk("lat_count", 32'(bus.count), 32'(n0));
    chk("lat_clr0",  32'(bus.rx_flag_clr), 32'(0));
    bus.rd_en = (mode == 1); bus.flush = (mode == 2); bus.ovr_clr = (mode == 3);
    @(posedge clk);
    @(negedge clk);
    bus.rd_en = 1'b0; bus.flush = 1'b0; bus.ovr_clr = 1'b0;
    if (mode == 2) begin
      q.delete();
      m_drop = 0;
    end else begin
      if (mode == 1 && q.size() > 0) void'(q.pop_front());
      if (mode == 3) m_ovr = 1'b0;
      if (DISCARD && perr)          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      else if (q.size() == DEPTH)   m_ovr = 1'b1;
      else                          q.push_back(d);
    end
    chk("clr_pulse", 32'(bus.rx_flag_clr), 32'(1));
    check_state("push");
    @(negedge clk);
    chk("clr_once", 32'(bus.rx_flag_clr), 32'(0));
    repeat (hold) @(negedge clk);
    chk("one_push", 32'(bus.count), 32'(q.size()));
    bus.rx_flag = 1'b0; bus.parity_error = 1'b0;
  endtask

  task automatic pop_byte();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_state("pop");
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    q.delete();
    m_drop = 0;
    check_state("flush");
  endtask

  task automatic pulse_ovr_clr();
    @(negedge clk);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    m_ovr = 1'b0;
    check_state("ovr_clr");
  endtask

  initial begin
    logic [7:0] d;
    n_rst = 1'b0;
    bus.rx_flag = 1'b0; bus.Rx_Data = '0; bus.parity_error = 1'b0;
    bus.rd_en = 1'b0; bus.flush = 1'b0; bus.ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    chk("reset.clr", 32'(bus.rx_flag_clr), 32'(0));
    n_rst = 1'b1;

    // Single byte, then pop it
    send_byte(8'hA5, 1'b0, 0, 1);
    pop_byte();

    // Fill past capacity, overrun set, clear racing a new loss
    for (int i = 0; i <= int'(DEPTH); i++) send_byte(8'(i), 1'b0, 0, 0);
    send_byte(8'hEE, 1'b0, 3, 0);
    for (int i = 0; i < int'(DEPTH); i++) pop_byte();
    pulse_ovr_clr();

    // Push and pop on the same edge, then pointer wrap with random traffic
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 0, 0);
    send_byte(8'h5A, 1'b0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'($urandom), 1'b0, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) pop_byte();
    end
    while (q.size() > 0) pop_byte();
    pop_byte();

    // Random parity flags; dropped or kept depending on build
    for (int i = 0; i < 6; i++)
      send_byte(8'($urandom), logic'($urandom_range(0, 3) == 0), 0, 0);

    // Flush on the push edge
    send_byte(8'h33, 1'b0, 0, 0);
    send_byte(8'h44, 1'b0, 2, 0);

    // Parity discard pair
    pulse_flush();
    send_byte(8'h11, 1'b1, 0, 0);
    send_byte(8'h22, 1'b0, 0, 0);
`ifdef UART_RX_PARITY_DISCARD_EN
    chk("par.count", 32'(bus.count), 32'(1));
    chk("par.data",  32'(bus.rd_data), 32'(8'h22));
    chk("par.drop",  32'(parity_drop_cnt), 32'(1));
`endif

    // Reach overrun, then reset during RXF_CLEAR with rx_flag still high
    for (int i = 0; i <= int'(DEPTH) && !m_ovr; i++) send_byte(8'($urandom), 1'b0, 0, 0);
    check_state("pre_reset");
    d = 8'($urandom);
    @(negedge clk);
    bus.rx_flag = 1'b1; bus.Rx_Data = d;
    @(posedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    q.delete(); m_ovr = 1'b0; m_drop = 0;
    check_state("async_rst");
    chk("async_rst.clr", 32'(bus.rx_flag_clr), 32'(0));
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    q.push_back(d);
    chk("recap.clr", 32'(bus.rx_flag_clr), 32'(1));
    check_state("recap");
    @(negedge clk);
    chk("recap.clr_once", 32'(bus.rx_flag_clr), 32'(0));
    bus.rx_flag = 1'b0;
    pop_byte();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
